// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority data-memory arbiter with external-port starvation guard.
// Optional DMEM_ARB_STATS_EN adds saturating grant/stall counters.
module dmem_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_read,
    input  logic [3:0]        cpu_writeb,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_stall,
    output logic [31:0]       cpu_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [3:0]        ext_be,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [31:0]       ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [31:0]       ext_rdata,
    output logic              mem_read,
    output logic [3:0]        mem_writeb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       stat_ext_grants,
    output logic [15:0]       stat_cpu_stalls
`endif
);

    typedef enum logic {S_CPU, S_FORCE} state_t;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       rd_owner_q, rd_owner_d;
    logic       cpu_act;
    logic       force_gnt;

    always_comb begin
        cpu_act   = cpu_read | (|cpu_writeb);
        force_gnt = (state_q == S_FORCE) & ext_req;
        ext_gnt   = rst_n & ext_req & (force_gnt | ~cpu_act);
        cpu_stall = rst_n & force_gnt & cpu_act;

        // Idle bus still carries the CPU address/data so the pipeline path stays quiet.
        mem_read   = 1'b0;
        mem_writeb = 4'b0000;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        if (ext_gnt) begin
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
            if (ext_we) begin
                mem_writeb = ext_be;
            end else begin
                mem_read = 1'b1;
            end
        end else if (rst_n && cpu_act) begin
            mem_read   = cpu_read;
            mem_writeb = cpu_writeb;
        end

        wait_cnt_d = wait_cnt_q;
        state_d    = state_q;
        if (ext_gnt || !ext_req) begin
            wait_cnt_d = 8'd0;
            state_d    = S_CPU;
        end else begin
            if (wait_cnt_q < STARVE_LIM) begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
            if (wait_cnt_d == STARVE_LIM) begin
                state_d = S_FORCE;
            end
        end

        // Only an external read needs its data steered back next cycle.
        rd_owner_d = ext_gnt & ~ext_we;
    end

    assign ext_rvalid = rd_owner_q;
    assign ext_rdata  = mem_rdata;
    assign cpu_rdata  = mem_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_CPU;
            wait_cnt_q <= 8'd0;
            rd_owner_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rd_owner_q <= rd_owner_d;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_ext_grants_q, stat_cpu_stalls_q;

    always_ff @(posedge clk) begin
        if (!rst_n || stat_clr) begin
            stat_ext_grants_q <= 16'd0;
            stat_cpu_stalls_q <= 16'd0;
        end else begin
            if (ext_gnt && stat_ext_grants_q != 16'hFFFF) begin
                stat_ext_grants_q <= stat_ext_grants_q + 16'd1;
            end
            if (cpu_stall && stat_cpu_stalls_q != 16'hFFFF) begin
                stat_cpu_stalls_q <= stat_cpu_stalls_q + 16'd1;
            end
        end
    end

    assign stat_ext_grants = stat_ext_grants_q;
    assign stat_cpu_stalls = stat_cpu_stalls_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter with a behavioural dmem.
module tb_dmem_arbiter;

    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpu_read;
    logic [3:0]        cpu_writeb;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_stall;
    logic [31:0]       cpu_rdata;
    logic              ext_req;
    logic              ext_we;
    logic [3:0]        ext_be;
    logic [ADDR_W-1:0] ext_addr;
    logic [31:0]       ext_wdata;
    logic              ext_gnt;
    logic              ext_rvalid;
    logic [31:0]       ext_rdata;
    logic              mem_read;
    logic [3:0]        mem_writeb;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic              stat_clr;
    logic [15:0]       stat_ext_grants;
    logic [15:0]       stat_cpu_stalls;
`endif

    int ncmp = 0;
    int nerr = 0;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_read   (cpu_read),
        .cpu_writeb (cpu_writeb),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_be     (ext_be),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .mem_read   (mem_read),
        .mem_writeb (mem_writeb),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_clr        (stat_clr),
        .stat_ext_grants (stat_ext_grants),
        .stat_cpu_stalls (stat_cpu_stalls)
`endif
    );

    // Behavioural dmem: byte writes, registered read; preloaded while reset is held.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[11'h020] <= 32'hAAAA5555;
            mem[11'h030] <= 32'h11223344;
            mem[11'h050] <= 32'h00000000;
        end else begin
            if (mem_read) mem_rdata <= mem[mem_addr];
            for (int b = 0; b < 4; b++) begin
                if (mem_writeb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_read = 1'b1; cpu_writeb = 4'b0000; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 1'b1; ext_we = 1'b1; ext_be = 4'hF; ext_addr = '0; ext_wdata = '0;
`ifdef DMEM_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        // Reset: everything quiet even with both sides requesting
        cyc(); settle();
        check("rst_gnt", 32'(ext_gnt), 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_writeb", 32'(mem_writeb), 32'd0);
        cyc(); settle();
        check("rst_rvalid", 32'(ext_rvalid), 32'd0);
        cyc();
        rst_n = 1'b1; cpu_read = 1'b0; ext_req = 1'b0;

        // Idle CPU: ext write then ext read of 0x010
        cyc();
        ext_req = 1'b1; ext_we = 1'b1; ext_be = 4'hF; ext_addr = 11'h010; ext_wdata = 32'hDEADBEEF;
        settle();
        check("idle_wr_gnt", 32'(ext_gnt), 32'd1);
        check("idle_wr_writeb", 32'(mem_writeb), 32'hF);
        check("idle_wr_read", 32'(mem_read), 32'd0);
        check("idle_wr_addr", 32'(mem_addr), 32'h010);
        check("idle_wr_wdata", mem_wdata, 32'hDEADBEEF);
        cyc();
        ext_we = 1'b0;
        settle();
        check("idle_rd_gnt", 32'(ext_gnt), 32'd1);
        check("idle_rd_read", 32'(mem_read), 32'd1);
        check("idle_rd_writeb", 32'(mem_writeb), 32'd0);
        cyc();
        ext_req = 1'b0;
        settle();
        check("idle_rvalid", 32'(ext_rvalid), 32'd1);
        check("idle_rdata", ext_rdata, 32'hDEADBEEF);
        check("idle_nogrant", 32'(ext_gnt), 32'd0);
        cyc(); settle();
        check("idle_rvalid_drop", 32'(ext_rvalid), 32'd0);

        // Partial write of byte 1 over 0x11223344
        cyc();
        ext_req = 1'b1; ext_we = 1'b1; ext_be = 4'b0010; ext_addr = 11'h030; ext_wdata = 32'h0000AB00;
        settle();
        check("part_wr_gnt", 32'(ext_gnt), 32'd1);
        check("part_wr_writeb", 32'(mem_writeb), 32'b0010);
        cyc();
        ext_we = 1'b0;
        settle();
        check("part_rd_gnt", 32'(ext_gnt), 32'd1);
        cyc();
        ext_req = 1'b0;
        settle();
        check("part_rvalid", 32'(ext_rvalid), 32'd1);
        check("part_rdata", ext_rdata, 32'h1122AB44);

        // Busy CPU: 8 ungranted cycles, then one forced grant with a stall
        cyc();
        cpu_read = 1'b1; cpu_addr = 11'h040;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 11'h010;
        for (int i = 0; i < 8; i++) begin
            settle();
            check("starve_wait_gnt", 32'(ext_gnt), 32'd0);
            check("starve_wait_stall", 32'(cpu_stall), 32'd0);
            cyc();
        end
        settle();
        check("starve_force_gnt", 32'(ext_gnt), 32'd1);
        check("starve_force_stall", 32'(cpu_stall), 32'd1);
        check("starve_force_addr", 32'(mem_addr), 32'h010);
        check("starve_force_read", 32'(mem_read), 32'd1);
        cyc();
        ext_req = 1'b0;
        settle();
        check("starve_resume_stall", 32'(cpu_stall), 32'd0);
        check("starve_resume_addr", 32'(mem_addr), 32'h040);
        check("starve_rvalid", 32'(ext_rvalid), 32'd1);
        check("starve_rdata", ext_rdata, 32'hDEADBEEF);
        cyc(); settle();
        check("starve_after_stall", 32'(cpu_stall), 32'd0);
        check("starve_after_rvalid", 32'(ext_rvalid), 32'd0);

        // Conflict: forced ext write to 0x020 while the CPU keeps reading 0x020
        cyc();
        cpu_addr = 11'h020;
        ext_req = 1'b1; ext_we = 1'b1; ext_be = 4'hF; ext_addr = 11'h020; ext_wdata = 32'h12345678;
        for (int i = 0; i < 8; i++) begin
            settle();
            check("cf_wait_gnt", 32'(ext_gnt), 32'd0);
            if (i == 1) check("cf_old_data", cpu_rdata, 32'hAAAA5555);
            cyc();
        end
        settle();
        check("cf_force_gnt", 32'(ext_gnt), 32'd1);
        check("cf_force_stall", 32'(cpu_stall), 32'd1);
        check("cf_force_writeb", 32'(mem_writeb), 32'hF);
        cyc();
        ext_req = 1'b0;
        settle();
        check("cf_retry_stall", 32'(cpu_stall), 32'd0);
        check("cf_retry_read", 32'(mem_read), 32'd1);
        check("cf_retry_addr", 32'(mem_addr), 32'h020);
        cyc(); settle();
        check("cf_new_data", cpu_rdata, 32'h12345678);

        // Withdrawal at wait_cnt = 5 restarts counting from zero
        cyc();
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 11'h010;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("wd_pre_gnt", 32'(ext_gnt), 32'd0);
            cyc();
        end
        ext_req = 1'b0;
        settle();
        check("wd_drop_gnt", 32'(ext_gnt), 32'd0);
        cyc();
        ext_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            settle();
            check("wd_restart_gnt", 32'(ext_gnt), 32'd0);
            cyc();
        end
        settle();
        check("wd_force_gnt", 32'(ext_gnt), 32'd1);
        check("wd_force_stall", 32'(cpu_stall), 32'd1);
        cyc();
        ext_req = 1'b0;
        settle();
        check("wd_resume_stall", 32'(cpu_stall), 32'd0);

`ifdef DMEM_ARB_STATS_EN
        check("stat_grants", 32'(stat_ext_grants), 32'd7);
        check("stat_stalls", 32'(stat_cpu_stalls), 32'd3);
        cyc();
        stat_clr = 1'b1;
        cyc();
        stat_clr = 1'b0;
        settle();
        check("stat_clr_grants", 32'(stat_ext_grants), 32'd0);
        check("stat_clr_stalls", 32'(stat_cpu_stalls), 32'd0);
`endif

        // Reset asserted in the forced cycle aborts the pending ext write
        cyc();
        ext_req = 1'b1; ext_we = 1'b1; ext_be = 4'hF; ext_addr = 11'h050; ext_wdata = 32'hCAFEF00D;
        repeat (8) cyc();
        rst_n = 1'b0;
        settle();
        check("rf_gnt", 32'(ext_gnt), 32'd0);
        check("rf_writeb", 32'(mem_writeb), 32'd0);
        check("rf_stall", 32'(cpu_stall), 32'd0);
        check("rf_read", 32'(mem_read), 32'd0);
        cyc();
        rst_n = 1'b1;
        settle();
        check("rf_state_cpu_gnt", 32'(ext_gnt), 32'd0);
        check("rf_state_cpu_stall", 32'(cpu_stall), 32'd0);
        check("rf_cpu_served", 32'(mem_read), 32'd1);
        cyc();
        ext_req = 1'b0; cpu_read = 1'b0;
        settle();
        check("rf_no_write", mem[11'h050], 32'h00000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
